// File: rtl/div_seq.sv
// Sequential RV32M divider: restoring shift-subtract, one quotient bit per clock,
// fixed 33-clock latency from the accepting edge to the done pulse.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             is_signed;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // op[0]=0 selects the signed variants (DIV, REM); op[1]=1 selects the remainder.
    assign is_signed = ~op[0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        a_raw_d   = a_raw_q;
        dvsr_d    = dvsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {2'b00, dvsr_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    a_raw_d   = dividend;
                    dvsr_d    = (is_signed && divisor[WIDTH-1])  ? (0 - divisor)  : divisor;
                    quo_d     = (is_signed && dividend[WIDTH-1]) ? (0 - dividend) : dividend;
                    rem_d     = '0;
                    count_d   = '0;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // A borrow out of the extended difference means the trial subtraction failed.
                if (diff[WIDTH+1]) begin
                    rem_d = shifted[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dvsr_q == '0) begin
                    result_d = op_q[1] ? a_raw_q : '1;
                end else if (op_q[1]) begin
                    result_d = neg_rem_q ? (0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                end else begin
                    result_d = neg_quo_q ? (0 - quo_q) : quo_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is reset, including the datapath, so an aborted operation leaves no residue.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_raw_q   <= '0;
            dvsr_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_raw_q   <= a_raw_d;
            dvsr_q    <= dvsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: the driver queues expected results at the accepting
// edge, the monitor pops and checks value and latency on every done pulse.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] exp;
        int           acc;
        int           tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", W'(prev_done), '0);
            check("pending_on_done", W'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check($sformatf("result_%0d", mon_e.tag), result, mon_e.exp);
                check($sformatf("latency_%0d", mon_e.tag), W'(cyc - mon_e.acc), 33);
            end
        end
        prev_done = done;
    end

    task automatic push_exp(input logic [W-1:0] exp, input int tag);
        exp_t e;
        e.exp = exp;
        e.acc = cyc;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int tag);
        @(negedge clk);
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(exp, tag);
        start = 1'b0;
        check($sformatf("busy_after_accept_%0d", tag), W'(busy), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int tag);
        issue(o, a, b, exp, tag);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got;

        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), 0);
        check("reset_done", W'(done), 0);
        check("reset_result", result, 0);
        rst_n = 1'b1;

        // Basic unsigned and signed cases
        run(2'b01, 100, 7, 14, 1);
        repeat (5) @(negedge clk);
        check("result_held", result, 14);
        run(2'b11, 100, 7, 2, 2);
        run(2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 3);
        run(2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 4);
        run(2'b10, 7, 32'hFFFF_FFFE, 1, 5);
        run(2'b00, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 6);

        // Divide by zero
        run(2'b01, 5, 0, 32'hFFFF_FFFF, 10);
        run(2'b11, 5, 0, 5, 11);
        run(2'b00, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF, 12);
        run(2'b10, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, 13);

        // Overflow and full-range
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 20);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 21);
        run(2'b01, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 22);

        // start held high with scrambled operands; second op accepted after done
        @(negedge clk);
        op = 2'b01;
        dividend = 100;
        divisor = 7;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(14, 50);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                op = 2'b11;
                dividend = 100;
                divisor = 7;
                got = 1'b1;
            end else begin
                op = 2'($urandom);
                dividend = $urandom;
                divisor = $urandom;
            end
        end
        check("held_start_done_seen", W'(got), 1);
        @(posedge clk);
        #1;
        push_exp(2, 51);
        start = 1'b0;
        check("busy_second_accept", W'(busy), 1);
        wait_drain();

        // Asynchronous reset at E10 aborts the operation
        issue(2'b01, 1000, 3, 333, 60);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", W'(busy), 0);
        check("abort_done", W'(done), 0);
        check("abort_result", result, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_result_held", result, 0);
        run(2'b01, 9, 3, 3, 61);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
